// File: rtl/decade_2421_if.sv
// Bus between a 2421-code source and the decade checker: the sampled code
// stream in one direction, the decoded digit and integrity status back.
interface decade_2421_if #(
  parameter int TENS_W = 8,
  parameter int ERR_W  = 8
);
  logic              in_valid;
  logic [3:0]        code_in;
  logic [3:0]        digit;
  logic              digit_valid;
  logic              code_err;
  logic              seq_err;
  logic              locked;
  logic [TENS_W-1:0] tens;
  logic [ERR_W-1:0]  err_cnt;

  // Source side: drives the code stream, observes the checker status.
  modport master (
    output in_valid, code_in,
    input  digit, digit_valid, code_err, seq_err, locked, tens, err_cnt
  );

  // Checker side.
  modport slave (
    input  in_valid, code_in,
    output digit, digit_valid, code_err, seq_err, locked, tens, err_cnt
  );
endinterface

// File: rtl/decade_2421_checker.sv
// Decodes a 2421-coded digit stream, tracks lock onto the 0..9 counting
// sequence, counts completed decades while locked and counts errors.
module decade_2421_checker #(
  parameter int LOCK_CNT = 2,
  parameter int TENS_W   = 8,
  parameter int ERR_W    = 8
) (
  input  logic          clk,
  input  logic          rst,
  decade_2421_if.slave  bus
);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_e;

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);

  state_e            state_q, state_d;
  logic [3:0]        match_cnt_q, match_cnt_d;
  logic [3:0]        expected_q, expected_d;
  logic [3:0]        digit_q, digit_d;
  logic              digit_valid_q, digit_valid_d;
  logic              code_err_q, code_err_d;
  logic              seq_err_q, seq_err_d;
  logic [TENS_W-1:0] tens_q, tens_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

  logic              legal;
  logic [3:0]        dec;
  logic [3:0]        succ;
  logic [ERR_W-1:0]  err_inc;

  // Decode the incoming code: 0-4 map straight, 11-15 map to 5-9.
  always_comb begin
    legal = 1'b0;
    dec   = 4'd0;
    if (bus.code_in <= 4'd4) begin
      legal = 1'b1;
      dec   = bus.code_in;
    end else if (bus.code_in >= 4'd11) begin
      legal = 1'b1;
      dec   = bus.code_in - 4'd6;
    end
  end

  assign succ    = (dec == 4'd9) ? 4'd0 : dec + 4'd1;
  assign err_inc = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;

  // Next-state and output decision for one sample.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves a latch.
    state_d       = state_q;
    match_cnt_d   = match_cnt_q;
    expected_d    = expected_q;
    digit_d       = digit_q;
    tens_d        = tens_q;
    err_cnt_d     = err_cnt_q;
    digit_valid_d = 1'b0;
    code_err_d    = 1'b0;
    seq_err_d     = 1'b0;

    if (bus.in_valid) begin
      if (legal) begin
        digit_d       = dec;
        digit_valid_d = 1'b1;
        expected_d    = succ;
      end else begin
        code_err_d = 1'b1;
      end

      unique case (state_q)
        HUNT: begin
          if (legal) begin
            match_cnt_d = 4'd1;
            state_d     = (LOCK_N == 4'd1) ? LOCKED : CHECK;
          end
        end
        CHECK: begin
          if (!legal) begin
            match_cnt_d = 4'd0;
            err_cnt_d   = err_inc;
            state_d     = HUNT;
          end else if (dec == expected_q) begin
            match_cnt_d = match_cnt_q + 4'd1;
            if (match_cnt_q + 4'd1 >= LOCK_N) state_d = LOCKED;
          end else begin
            match_cnt_d = 4'd1;
          end
        end
        LOCKED: begin
          if (!legal) begin
            match_cnt_d = 4'd0;
            err_cnt_d   = err_inc;
            state_d     = HUNT;
          end else if (dec == expected_q) begin
            // An in-sequence 0 can only follow a 9: one decade completed.
            if (dec == 4'd0) tens_d = tens_q + 1'b1;
          end else begin
            seq_err_d   = 1'b1;
            err_cnt_d   = err_inc;
            match_cnt_d = 4'd1;
            state_d     = (LOCK_N == 4'd1) ? LOCKED : CHECK;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // State and output registers; rst clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses <= so all registers update from pre-edge values.
    if (rst) begin
      state_q       <= HUNT;
      match_cnt_q   <= '0;
      expected_q    <= '0;
      digit_q       <= '0;
      digit_valid_q <= 1'b0;
      code_err_q    <= 1'b0;
      seq_err_q     <= 1'b0;
      tens_q        <= '0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      match_cnt_q   <= match_cnt_d;
      expected_q    <= expected_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      code_err_q    <= code_err_d;
      seq_err_q     <= seq_err_d;
      tens_q        <= tens_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign bus.digit       = digit_q;
  assign bus.digit_valid = digit_valid_q;
  assign bus.code_err    = code_err_q;
  assign bus.seq_err     = seq_err_q;
  assign bus.locked      = (state_q == LOCKED);
  assign bus.tens        = tens_q;
  assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_decade_2421_checker.sv
// Self-checking bench for decade_2421_checker: a fixed vector table for the
// counting sequence, hand sequences for error/recovery corners, and a
// randomized stream compared against a sample-level reference model.
module tb_decade_2421_checker;

  localparam int LOCK_CNT = 2;
  localparam int TENS_W   = 8;
  localparam int ERR_W    = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  decade_2421_if #(.TENS_W(TENS_W), .ERR_W(ERR_W)) bus ();

  decade_2421_checker #(.LOCK_CNT(LOCK_CNT), .TENS_W(TENS_W), .ERR_W(ERR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // 2421 code for each digit 0..9.
  int enc [10] = '{0, 1, 2, 3, 4, 11, 12, 13, 14, 15};

  // Reference model: run = consecutive in-sequence legal samples (0 = hunting).
  int m_run, m_exp, m_digit, m_tens, m_err;
  bit m_dv, m_ce, m_se;

  function automatic int decode(input int code);
    for (int i = 0; i < 10; i++) if (enc[i] == code) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_run = 0; m_exp = 0; m_digit = 0; m_tens = 0; m_err = 0;
    m_dv = 0; m_ce = 0; m_se = 0;
  endtask

  task automatic model_step(input bit v, input int code);
    int  d;
    bit  was_locked, in_seq;
    m_dv = 0; m_ce = 0; m_se = 0;
    if (!v) return;
    d = decode(code);
    if (d < 0) begin
      m_ce = 1;
      if (m_run > 0 && m_err < (1 << ERR_W) - 1) m_err++;
      m_run = 0;
    end else begin
      was_locked = (m_run >= LOCK_CNT);
      in_seq     = (m_run > 0) && (d == m_exp);
      m_dv = 1;
      m_digit = d;
      if (in_seq) begin
        if (was_locked && d == 0) m_tens = (m_tens + 1) % (1 << TENS_W);
        m_run = (m_run + 1 > LOCK_CNT) ? LOCK_CNT : m_run + 1;
      end else begin
        if (was_locked) begin
          m_se = 1;
          if (m_err < (1 << ERR_W) - 1) m_err++;
        end
        m_run = 1;
      end
      m_exp = (d + 1) % 10;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("digit",       int'(bus.digit),       m_digit);
    check("digit_valid", int'(bus.digit_valid), int'(m_dv));
    check("code_err",    int'(bus.code_err),    int'(m_ce));
    check("seq_err",     int'(bus.seq_err),     int'(m_se));
    check("locked",      int'(bus.locked),      int'(m_run >= LOCK_CNT));
    check("tens",        int'(bus.tens),        m_tens);
    check("err_cnt",     int'(bus.err_cnt),     m_err);
  endtask

  // Apply one sample and compare against the model #1 after the edge.
  task automatic step(input bit v, input int code);
    @(negedge clk);
    bus.in_valid = v;
    bus.code_in  = 4'(code);
    @(posedge clk);
    model_step(v, code);
    #1 check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_digit"},  int'(bus.digit),       0);
    check({tag, "_dv"},     int'(bus.digit_valid), 0);
    check({tag, "_cerr"},   int'(bus.code_err),    0);
    check({tag, "_serr"},   int'(bus.seq_err),     0);
    check({tag, "_locked"}, int'(bus.locked),      0);
    check({tag, "_tens"},   int'(bus.tens),        0);
    check({tag, "_errcnt"}, int'(bus.err_cnt),     0);
  endtask

  typedef struct {
    int code;
    int digit;
    bit locked;
    int tens;
  } vec_t;

  vec_t vecs [11];

  initial begin
    bus.in_valid = 1'b0;
    bus.code_in  = 4'd0;
    model_reset();

    // Counting-sequence table: digit lags one clock, locked after 2nd sample.
    for (int i = 0; i < 11; i++) begin
      vecs[i].code   = enc[i % 10];
      vecs[i].digit  = i % 10;
      vecs[i].locked = (i >= 1);
      vecs[i].tens   = (i == 10) ? 1 : 0;
    end

    rst = 1'b1;
    #12;
    check_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.code_in  = 4'(vecs[i].code);
      @(posedge clk);
      model_step(1'b1, vecs[i].code);
      #1;
      check("tbl_digit",  int'(bus.digit),       vecs[i].digit);
      check("tbl_dv",     int'(bus.digit_valid), 1);
      check("tbl_locked", int'(bus.locked),      int'(vecs[i].locked));
      check("tbl_tens",   int'(bus.tens),        vecs[i].tens);
      check("tbl_errs",   int'(bus.code_err) + int'(bus.seq_err) + int'(bus.err_cnt), 0);
    end

    // Sparse valid: one gap cycle after every sample, one more decade.
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, enc[i % 10]);
      step(1'b0, 0);
    end
    check("gap_tens",  int'(bus.tens),  2);
    check("gap_digit", int'(bus.digit), 0);

    // Illegal code while locked at 3, then relock on 12,13.
    step(1'b1, enc[1]); step(1'b1, enc[2]); step(1'b1, enc[3]);
    step(1'b1, 7);
    check("ill_cerr",   int'(bus.code_err), 1);
    check("ill_locked", int'(bus.locked),   0);
    check("ill_errcnt", int'(bus.err_cnt),  1);
    check("ill_digit",  int'(bus.digit),    3);
    step(1'b1, 12);
    check("relock1_locked", int'(bus.locked), 0);
    step(1'b1, 13);
    check("relock2_locked", int'(bus.locked), 1);
    check("relock2_digit",  int'(bus.digit),  7);

    // Out-of-sequence code while locked at 4, then relock on 14.
    for (int d = 8; d <= 14; d++) step(1'b1, enc[d % 10]);
    check("pre_seq_tens", int'(bus.tens), 3);
    step(1'b1, 13);
    check("seq_serr",   int'(bus.seq_err),  1);
    check("seq_digit",  int'(bus.digit),    7);
    check("seq_errcnt", int'(bus.err_cnt),  2);
    check("seq_locked", int'(bus.locked),   0);
    step(1'b1, 14);
    check("seq_relock", int'(bus.locked), 1);
    check("seq_tens",   int'(bus.tens),   3);

    // Randomized stream against the model.
    do_reset();
    begin
      int d;
      d = 0;
      for (int i = 0; i < 1500; i++) begin
        int r;
        r = int'($urandom_range(99));
        if ($urandom_range(9) < 2) step(1'b0, int'($urandom_range(15)));
        else if (r < 70) begin step(1'b1, enc[d]); d = (d + 1) % 10; end
        else if (r < 85) begin d = int'($urandom_range(9)); step(1'b1, enc[d]); d = (d + 1) % 10; end
        else step(1'b1, int'($urandom_range(15)));
      end
    end

    // 300 decades locked: tens wraps to 300 mod 256.
    do_reset();
    for (int i = 0; i <= 3000; i++) step(1'b1, enc[i % 10]);
    check("wrap_tens", int'(bus.tens), 44);

    // Asynchronous reset between edges clears outputs at once.
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1 check_zero("async");
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 15);
    check("post_rst_digit9", int'(bus.digit), 9);
    step(1'b1, 0);
    check("post_rst_digit0", int'(bus.digit), 0);
    check("post_rst_tens",   int'(bus.tens),  0);

    // 260 counted errors: legal (HUNT->CHECK) then illegal (counted in CHECK).
    do_reset();
    for (int i = 0; i < 260; i++) begin
      step(1'b1, enc[i % 10]);
      step(1'b1, 8);
    end
    check("sat_errcnt", int'(bus.err_cnt), 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decade_2421_checker.md
Name: decade_2421_checker

Overview:
Receive-side partner of the 2421-code decade counter. Samples a 4-bit 2421 code stream and decodes each code to a binary digit 0-9. Checks that successive codes follow the counting sequence 0,1,2,3,4,11,12,13,14,15,0. Counts completed decades once locked. Sits on the counter's output bus, or on any link carrying 2421 digits, as a decoder and integrity monitor.

Parameters:
LOCK_CNT, 2, consecutive in-sequence legal samples needed to enter LOCKED (legal range 1-15)
TENS_W, 8, width of decade counter output tens
ERR_W, 8, width of saturating error counter err_cnt

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  code_in is sampled on this clk edge
code_in  input  4  2421-coded digit
digit  output  4  decoded binary digit of last legal sample (0-9)
digit_valid  output  1  one-cycle pulse: digit updated this cycle
code_err  output  1  one-cycle pulse: illegal code sampled
seq_err  output  1  one-cycle pulse: legal code out of sequence while LOCKED
locked  output  1  level, high while FSM in LOCKED
tens  output  TENS_W  count of 9->0 wraps seen in LOCKED, modulo 2^TENS_W
err_cnt  output  ERR_W  code_err + seq_err events, saturates at all-ones

Behaviour:
- Reset: asynchronous assert; all outputs 0; state HUNT; internal match_cnt = 0, expected = 0.
- Decode: codes 0-4 decode to 0-4. Codes 11-15 decode to 5-9. Codes 5-10 are illegal.
- Successor of digit d is (d+1) mod 10. expected always holds the successor of the last legal digit.
- All outputs are registered. Latency: one clk from the sampling edge to the outputs.
- in_valid low: no state change, all pulses 0, levels and counters hold.
- When in_valid is high:
  - Legal sample: digit <= decoded value, digit_valid = 1.
  - Illegal sample: digit holds, digit_valid = 0, code_err = 1.
- FSM, transitions taken only when in_valid is high:
  - HUNT:
    - Legal: match_cnt <= 1. Go to LOCKED if LOCK_CNT == 1, else go to CHECK.
    - Illegal: code_err, stay in HUNT. err_cnt is not incremented in HUNT.
  - CHECK:
    - Legal and equal to expected: match_cnt++. Go to LOCKED when match_cnt reaches LOCK_CNT.
    - Legal mismatch: realign, match_cnt <= 1, stay in CHECK, no seq_err.
    - Illegal: code_err, go to HUNT.
  - LOCKED:
    - Legal and equal to expected: stay. If previous digit was 9 and new digit is 0, tens++ (wraps at 2^TENS_W).
    - Legal mismatch: seq_err, err_cnt++, realign, match_cnt <= 1, go to CHECK. If LOCK_CNT == 1, stay in LOCKED instead.
    - Illegal: code_err, err_cnt++, go to HUNT.
- locked = (state == LOCKED). It deasserts in the same cycle as seq_err or code_err.
- tens increments only in LOCKED on an in-sequence 9->0 transition. Never increments on realign or on the first sample.
- err_cnt saturates at 2^ERR_W-1. No wrap.
- code_err and seq_err are mutually exclusive per sample.
- tens and err_cnt are cleared only by rst.
- rst asserted mid-stream: immediate return to the reset state. The first sample after deassert is treated as in HUNT.

Test Plan:
- Reset then feed the counter sequence 0,1,2,3,4,11,12,13,14,15,0 with in_valid high every cycle, LOCK_CNT=2 -> digit 0..9,0 with one-cycle lag; locked high from the cycle after the 2nd sample; tens = 1 after the final 0; no errors.
- Locked stream with in_valid toggling every other cycle -> outputs update only on valid cycles; pulses are 0 in gap cycles; tens and digit identical to the dense run.
- Locked at digit 3 (code 3), inject code 7 -> code_err pulse, locked drops, err_cnt = 1, digit stays 3. Then feed 12,13 -> back in LOCKED after two samples; digit = 7.
- Locked at digit 4, inject code 13 -> seq_err, digit = 7, err_cnt++, FSM in CHECK. Then feed 14 -> locked re-asserts, no tens increment.
- Run 300 full decades locked with TENS_W=8 -> tens wraps to 44 (300 mod 256). Force 260 errors with ERR_W=8 -> err_cnt holds at 255.
- Assert rst asynchronously between clk edges mid-stream -> all outputs 0 immediately, without waiting for a clk edge. Then feed 15,0 -> digit 9 then 0, tens stays 0 (first sample taken in HUNT).
